// File: rtl/pingpong_pkg.sv
// Constants and types shared by the writer and reader sides of the ping-pong frame buffer.
// Optional build macro used by the writer: FRAME_CHECKSUM_EN.
package pingpong_pkg;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int DW    = 8;

    typedef enum logic {
        FILL = 1'b0,
        WAIT = 1'b1
    } wr_state_e;

    typedef logic bank_t;

    // The writer always owns the bank the reader is not using.
    function automatic bank_t other_bank(input bank_t b);
        return ~b;
    endfunction

endpackage

// File: rtl/pingpong_wr_addr_gen.sv
// Write-pointer counter for one frame: increments per accepted byte, flags the last
// address of the frame and clears when the banks swap.
module pingpong_wr_addr_gen
    import pingpong_pkg::*;
(
    input  logic          clk,
    input  logic          resetn,
    input  logic          inc_i,
    input  logic          clr_i,
    output logic [AW-1:0] wptr_o,
    output logic          last_o
);

    logic [AW-1:0] wptr_q;
    logic [AW-1:0] wptr_d;

    always_comb begin
        wptr_d = wptr_q;
        if (clr_i) begin
            wptr_d = '0;
        end else if (inc_i) begin
            wptr_d = wptr_q + 1'b1;
        end
    end

    // NOTE: resetn is tested inside the clocked block, so the reset is synchronous.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
        end
    end

    assign wptr_o = wptr_q;
    assign last_o = (wptr_q == AW'(DEPTH - 1));

endmodule

// File: rtl/pingpong_frame_writer.sv
// Producer-side ping-pong frame writer: fills the bank the reader is not using and swaps banks.
// Build macro FRAME_CHECKSUM_EN adds frame_csum, the XOR of the bytes of the last completed frame.
module pingpong_frame_writer
    import pingpong_pkg::*;
(
    input  logic          clk,
    input  logic          resetn,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic          rd_frame_done,
    output logic          rd_bank,
    output logic          wr_en0,
    output logic          wr_en1,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          frame_swap,
`ifdef FRAME_CHECKSUM_EN
    output logic [DW-1:0] frame_csum,
`endif
    output logic [7:0]    frame_count
);

    wr_state_e     state_q;
    logic          in_ready_q;
    bank_t         rd_bank_q;
    logic          done_pending_q;
    logic          primed_q;
    logic          wr_en0_q;
    logic          wr_en1_q;
    logic [AW-1:0] wr_addr_q;
    logic [DW-1:0] wr_data_q;
    logic          frame_swap_q;
    logic [7:0]    frame_count_q;
`ifdef FRAME_CHECKSUM_EN
    logic [DW-1:0] csum_acc_q;
    logic [DW-1:0] frame_csum_q;
`endif

    logic          accept;
    logic          swap_go;
    logic [AW-1:0] wptr;
    logic          wptr_last;
    bank_t         wr_bank;

    // in_ready_q is only ever high in FILL, so it alone qualifies the handshake.
    assign accept  = in_valid && in_ready_q;
    assign swap_go = (state_q == WAIT) && (!primed_q || done_pending_q || rd_frame_done);
    assign wr_bank = other_bank(rd_bank_q);

    pingpong_wr_addr_gen u_addr_gen (
        .clk    (clk),
        .resetn (resetn),
        .inc_i  (accept),
        .clr_i  (swap_go),
        .wptr_o (wptr),
        .last_o (wptr_last)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= FILL;
            in_ready_q     <= 1'b0;
            rd_bank_q      <= 1'b0;
            done_pending_q <= 1'b0;
            primed_q       <= 1'b0;
            wr_en0_q       <= 1'b0;
            wr_en1_q       <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            frame_swap_q   <= 1'b0;
            frame_count_q  <= '0;
`ifdef FRAME_CHECKSUM_EN
            csum_acc_q     <= '0;
            frame_csum_q   <= '0;
`endif
        end else begin
            // Strobes are single-cycle; later assignments below override these defaults.
            wr_en0_q     <= 1'b0;
            wr_en1_q     <= 1'b0;
            frame_swap_q <= 1'b0;
            case (state_q)
                FILL: begin
                    in_ready_q <= 1'b1;
                    if (rd_frame_done) begin
                        done_pending_q <= 1'b1;
                    end
                    if (accept) begin
                        wr_en0_q  <= (wr_bank == 1'b0);
                        wr_en1_q  <= (wr_bank == 1'b1);
                        wr_addr_q <= wptr;
                        wr_data_q <= in_data;
`ifdef FRAME_CHECKSUM_EN
                        csum_acc_q <= csum_acc_q ^ in_data;
`endif
                        if (wptr_last) begin
                            state_q    <= WAIT;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (swap_go) begin
                        state_q        <= FILL;
                        in_ready_q     <= 1'b1;
                        rd_bank_q      <= ~rd_bank_q;
                        frame_swap_q   <= 1'b1;
                        frame_count_q  <= frame_count_q + 8'd1;
                        primed_q       <= 1'b1;
                        done_pending_q <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
                        frame_csum_q   <= csum_acc_q;
                        csum_acc_q     <= '0;
`endif
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign rd_bank     = rd_bank_q;
    assign wr_en0      = wr_en0_q;
    assign wr_en1      = wr_en1_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign frame_swap  = frame_swap_q;
    assign frame_count = frame_count_q;
`ifdef FRAME_CHECKSUM_EN
    assign frame_csum  = frame_csum_q;
`endif

endmodule

// File: tb/tb_pingpong_frame_writer.sv
// Self-checking bench for pingpong_frame_writer: directed frame scenarios plus random traffic,
// every cycle compared against a frame-level reference model.
module tb_pingpong_frame_writer;
    import pingpong_pkg::*;

    logic          clk = 1'b0;
    logic          resetn;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          rd_frame_done;
    logic          rd_bank;
    logic          wr_en0;
    logic          wr_en1;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          frame_swap;
    logic [7:0]    frame_count;
`ifdef FRAME_CHECKSUM_EN
    logic [DW-1:0] frame_csum;
`endif

    always #5 clk = ~clk;

    pingpong_frame_writer dut (
        .clk           (clk),
        .resetn        (resetn),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .rd_frame_done (rd_frame_done),
        .rd_bank       (rd_bank),
        .wr_en0        (wr_en0),
        .wr_en1        (wr_en1),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .frame_swap    (frame_swap),
`ifdef FRAME_CHECKSUM_EN
        .frame_csum    (frame_csum),
`endif
        .frame_count   (frame_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: bytes collected per frame, frame handed over when the reader is free.
    bit         m_ready, m_bank, m_swap, m_we0, m_we1;
    bit         m_waiting, m_pending, m_primed;
    int         m_fill_n, m_count, m_accepts;
    logic [7:0] m_addr, m_data, m_acc, m_csum;

    task automatic model_step(input bit v, input logic [7:0] d, input bit done, input bit rst_n);
        m_we0  = 0;
        m_we1  = 0;
        m_swap = 0;
        if (!rst_n) begin
            m_ready = 0; m_bank = 0; m_waiting = 0; m_pending = 0; m_primed = 0;
            m_fill_n = 0; m_count = 0; m_addr = 0; m_data = 0; m_acc = 0; m_csum = 0;
        end else if (!m_waiting) begin
            if (v && m_ready) begin
                if (m_bank) m_we0 = 1; else m_we1 = 1;
                m_addr = 8'(m_fill_n);
                m_data = d;
                m_acc  = m_acc ^ d;
                m_fill_n++;
                m_accepts++;
                if (m_fill_n == DEPTH) begin
                    m_waiting = 1;
                    m_fill_n  = 0;
                end
            end
            if (done) m_pending = 1;
            m_ready = !m_waiting;
        end else if (!m_primed || m_pending || done) begin
            m_bank    = !m_bank;
            m_swap    = 1;
            m_count   = (m_count + 1) % 256;
            m_primed  = 1;
            m_pending = 0;
            m_waiting = 0;
            m_csum    = m_acc;
            m_acc     = 0;
            m_ready   = 1;
        end
    endtask

    task automatic check_outputs();
        check("in_ready",    32'(in_ready),    32'(m_ready));
        check("rd_bank",     32'(rd_bank),     32'(m_bank));
        check("frame_swap",  32'(frame_swap),  32'(m_swap));
        check("frame_count", 32'(frame_count), 32'(m_count));
        check("wr_en0",      32'(wr_en0),      32'(m_we0));
        check("wr_en1",      32'(wr_en1),      32'(m_we1));
        check("wr_addr",     32'(wr_addr),     32'(m_addr));
        check("wr_data",     32'(wr_data),     32'(m_data));
`ifdef FRAME_CHECKSUM_EN
        check("frame_csum",  32'(frame_csum),  32'(m_csum));
`endif
    endtask

    task automatic cycle(input bit v, input logic [7:0] d, input bit done, input bit rst_n);
        resetn        = rst_n;
        in_valid      = v;
        in_data       = d;
        rd_frame_done = done;
        @(posedge clk);
        model_step(v, d, done, rst_n);
        @(negedge clk);
        check_outputs();
    endtask

    // Offer bytes base+index until n more have been accepted; optional reader pulses mid-fill
    // or on the final accept of the frame.
    task automatic fill_bytes(input logic [7:0] base, input int gap_pct, input int n,
                              input bit done_mid, input bit done_last);
        int target;
        int budget;
        bit v;
        bit dn;
        target = m_accepts + n;
        budget = 4000;
        while (m_accepts < target && budget > 0) begin
            v  = ($urandom_range(99) >= gap_pct);
            dn = 0;
            if (done_mid && (m_fill_n == 5 || m_fill_n == 11 || m_fill_n == 17)) dn = 1;
            if (done_last && v && m_ready && m_fill_n == DEPTH - 1) dn = 1;
            cycle(v, base + 8'(m_fill_n), dn, 1'b1);
            budget--;
        end
        if (m_accepts < target) check("fill_timeout", 32'(m_accepts), 32'(target));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'($urandom_range(1)), 8'($urandom), 1'b0, 1'b1);
    endtask

    initial begin
        // Reset state
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_count",    32'(frame_count), 32'd0);

        // Frame 1: swap without any reader pulse
        fill_bytes(8'h00, 0, DEPTH, 1'b0, 1'b0);
        check("f1_last_bank1", 32'(wr_en1), 32'd1);
        check("f1_last_addr",  32'(wr_addr), 32'd31);
        idle(1);
        check("f1_swap",  32'(frame_swap), 32'd1);
        check("f1_bank",  32'(rd_bank), 32'd1);
        check("f1_count", 32'(frame_count), 32'd1);

        // Frame 2: stalls in WAIT until the reader reports done
        fill_bytes(8'h20, 20, DEPTH, 1'b0, 1'b0);
        idle(100);
        check("f2_stall_ready", 32'(in_ready), 32'd0);
        check("f2_stall_bank",  32'(rd_bank), 32'd1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        check("f2_swap",  32'(frame_swap), 32'd1);
        check("f2_bank",  32'(rd_bank), 32'd0);
        check("f2_count", 32'(frame_count), 32'd2);

        // Frame 3: pulses during fill saturate into one pending swap
        fill_bytes(8'h40, 30, DEPTH, 1'b1, 1'b0);
        idle(1);
        check("f3_swap", 32'(frame_swap), 32'd1);

        // Frame 4: must wait for a fresh pulse
        fill_bytes(8'h60, 0, DEPTH, 1'b0, 1'b0);
        idle(20);
        check("f4_wait_count", 32'(frame_count), 32'd3);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);

        // Frame 5: pulse on the final accept edge
        fill_bytes(8'h80, 10, DEPTH, 1'b0, 1'b1);
        check("f5_last_oldbank", 32'(wr_en1), 32'd1);
        check("f5_no_swap_yet",  32'(frame_swap), 32'd0);
        idle(1);
        check("f5_swap", 32'(frame_swap), 32'd1);

        // Reset 10 bytes into frame 2
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        fill_bytes(8'hA0, 0, DEPTH, 1'b0, 1'b0);
        idle(1);
        fill_bytes(8'hC0, 0, 10, 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b0, 1'b0);
        check("mid_rst_bank",  32'(rd_bank), 32'd0);
        check("mid_rst_wr_en", 32'(wr_en0 | wr_en1), 32'd0);
        fill_bytes(8'hE0, 0, 1, 1'b0, 1'b0);
        check("post_rst_bank1", 32'(wr_en1), 32'd1);
        check("post_rst_addr0", 32'(wr_addr), 32'd0);

        // Checksum frame 0x01..0x20
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        fill_bytes(8'h01, 0, DEPTH, 1'b0, 1'b0);
        idle(1);
`ifdef FRAME_CHECKSUM_EN
        check("csum_frame", 32'(frame_csum), 32'h20);
        fill_bytes(8'h33, 25, 20, 1'b0, 1'b0);
        check("csum_hold", 32'(frame_csum), 32'h20);
`endif

        // Random traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(99) < 70), 8'($urandom),
                  1'($urandom_range(99) < 4), 1'($urandom_range(299) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
